// File: rtl/cordic_dual_mode_ctrl.sv
// Sequencing FSM for an iterative vectoring/rotation CORDIC datapath.
// Optional macro CORDIC_ABORT_EN adds an abort input that returns the controller to IDLE.
module cordic_dual_mode_ctrl #(
   parameter int ITER_W   = 5,
   parameter int MAX_ITER = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mode,
   input  logic [ITER_W-1:0] n_iter,
   input  logic              neg_x,
   input  logic              z_oor,
`ifdef CORDIC_ABORT_EN
   input  logic              abort,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic              load_x,
   output logic              load_y,
   output logic              load_z,
   output logic              load_d,
   output logic              d_src,
   output logic              clear_z,
   output logic [1:0]        sel_x,
   output logic [1:0]        sel_y,
   output logic [1:0]        sel_z,
   output logic [ITER_W-1:0] iteration_counter,
   output logic              busy
);

   localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(MAX_ITER - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      NORMALIZE,
      DECIDE,
      OPERATE,
      FINALIZE,
      OUT
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ITER_W-1:0] cnt;
   logic [ITER_W-1:0] cnt_nxt;
   logic [ITER_W-1:0] n_q;
   logic              mode_q;
   logic              accept;
   logic              abort_act;

   function automatic logic [ITER_W-1:0] clamp_iter(input logic [ITER_W-1:0] req);
      return (req > LAST_IDX) ? LAST_IDX : req;
   endfunction

`ifdef CORDIC_ABORT_EN
   assign abort_act = abort && (state != IDLE);
`else
   assign abort_act = 1'b0;
`endif

   assign d_src             = mode_q;
   assign busy              = (state != IDLE);
   assign iteration_counter = cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         n_q    <= '0;
         mode_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            mode_q <= mode;
            n_q    <= clamp_iter(n_iter);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_valid = 1'b0;
      load_x    = 1'b0;
      load_y    = 1'b0;
      load_z    = 1'b0;
      load_d    = 1'b0;
      clear_z   = 1'b0;
      sel_x     = 2'd0;
      sel_y     = 2'd0;
      sel_z     = 2'd0;

      // A result leaving OUT frees the slot in the same cycle, so a new request
      // can be taken without an IDLE bubble.
      in_ready = ((state == IDLE) || ((state == OUT) && out_ready)) && !abort_act;
      accept   = in_valid && in_ready;

      case (state)
         IDLE: begin
            if (accept) state_nxt = LOAD;
         end
         LOAD: begin
            load_x  = 1'b1;
            load_y  = 1'b1;
            cnt_nxt = '0;
            if (mode_q) begin
               load_z = 1'b1;
               sel_z  = 2'd3;
            end else begin
               clear_z = 1'b1;
            end
            state_nxt = (mode_q ? z_oor : neg_x) ? NORMALIZE : DECIDE;
         end
         NORMALIZE: begin
            load_x    = 1'b1;
            load_y    = 1'b1;
            load_z    = 1'b1;
            state_nxt = DECIDE;
         end
         DECIDE: begin
            load_d    = 1'b1;
            state_nxt = OPERATE;
         end
         OPERATE: begin
            load_x = 1'b1;
            load_y = 1'b1;
            load_z = 1'b1;
            sel_x  = 2'd2;
            sel_y  = 2'd2;
            sel_z  = 2'd1;
            if (cnt == n_q) begin
               state_nxt = FINALIZE;
            end else begin
               cnt_nxt   = cnt + 1'b1;
               state_nxt = DECIDE;
            end
         end
         FINALIZE: begin
            if (mode_q) begin
               load_x = 1'b1;
               load_y = 1'b1;
               sel_x  = 2'd3;
               sel_y  = 2'd3;
            end else begin
               load_z = 1'b1;
               sel_z  = 2'd2;
            end
            state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = in_valid ? LOAD : IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Abort wins over everything: no register writes, no result, counter frozen.
      if (abort_act) begin
         state_nxt = IDLE;
         cnt_nxt   = cnt;
         out_valid = 1'b0;
         load_x    = 1'b0;
         load_y    = 1'b0;
         load_z    = 1'b0;
         load_d    = 1'b0;
         clear_z   = 1'b0;
      end
   end

endmodule

// File: tb/tb_cordic_dual_mode_ctrl.sv
// Bench for cordic_dual_mode_ctrl: cycle-level expected-output queue plus directed scenarios.
// Define CORDIC_ABORT_EN to also exercise the abort input.
module tb_cordic_dual_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst, in_valid, mode, neg_x, z_oor, out_ready;
   logic [4:0] n_iter;
   logic       in_ready, out_valid, load_x, load_y, load_z, load_d, d_src, clear_z, busy;
   logic [1:0] sel_x, sel_y, sel_z;
   logic [4:0] iteration_counter;
`ifdef CORDIC_ABORT_EN
   logic       abort;
`endif

   always #5 clk = ~clk;

   cordic_dual_mode_ctrl #(.ITER_W(5), .MAX_ITER(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .n_iter(n_iter), .neg_x(neg_x), .z_oor(z_oor),
`ifdef CORDIC_ABORT_EN
      .abort(abort),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .load_x(load_x), .load_y(load_y),
      .load_z(load_z), .load_d(load_d), .d_src(d_src), .clear_z(clear_z),
      .sel_x(sel_x), .sel_y(sel_y), .sel_z(sel_z),
      .iteration_counter(iteration_counter), .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One expected cycle of register enables/selects while an operation runs.
   typedef struct {
      bit       lx, ly, lz, ld, cz;
      bit [1:0] sx, sy, sz;
      int       cnt;
      bit       is_load;
   } step_t;

   function automatic step_t mk(bit lx, bit ly, bit lz, bit ld, bit cz,
                                bit [1:0] sx, bit [1:0] sy, bit [1:0] sz, int cnt);
      step_t s;
      s.lx = lx; s.ly = ly; s.lz = lz; s.ld = ld; s.cz = cz;
      s.sx = sx; s.sy = sy; s.sz = sz; s.cnt = cnt; s.is_load = 1'b0;
      return s;
   endfunction

   function automatic logic [19:0] vec(step_t e, bit ov, bit ir, bit bs, bit ds, int c);
      return {e.lx, e.ly, e.lz, e.ld, e.cz, e.sx, e.sy, e.sz, ov, ir, bs, ds, 5'(c)};
   endfunction

   step_t q[$];
   bit    in_op    = 1'b0;
   bit    mq       = 1'b0;
   int    last_cnt = 0;
   int    pend_n   = 0;

   // Everything after LOAD depends on the normalize flag seen during LOAD.
   task automatic build_rest();
      if (mq ? z_oor : neg_x) q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i <= pend_n; i++) begin
         q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, i));
         q.push_back(mk(1, 1, 1, 0, 0, 2, 2, 1, i));
      end
      if (mq) q.push_back(mk(1, 1, 0, 0, 0, 3, 3, 0, pend_n));
      else    q.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, pend_n));
      last_cnt = pend_n;
   endtask

   always @(negedge clk) begin
      step_t       e, z;
      logic [19:0] act_v, exp_v;
      bit          acc, ab;
      int          cur;
      z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      act_v = {load_x, load_y, load_z, load_d, clear_z, sel_x, sel_y, sel_z,
               out_valid, in_ready, busy, d_src, iteration_counter};
      acc = 1'b0;
      ab  = 1'b0;
`ifdef CORDIC_ABORT_EN
      ab = (abort === 1'b1) && in_op;
`endif
      if (rst !== 1'b1) begin
         exp_v = vec(z, 0, 1, 0, 0, 0);
         q.delete(); in_op = 1'b0; mq = 1'b0; last_cnt = 0;
      end else if (!in_op) begin
         exp_v = vec(z, 0, 1, 0, mq, last_cnt);
         acc = in_valid;
      end else if (ab) begin
         cur = (q.size() > 0) ? q[0].cnt : last_cnt;
         exp_v = vec(z, 0, 0, 1, mq, cur);
         q.delete(); in_op = 1'b0; last_cnt = cur;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         exp_v = vec(e, 0, 0, 1, mq, e.cnt);
         if (e.is_load) build_rest();
      end else begin
         exp_v = vec(z, 1, out_ready, 1, mq, last_cnt);
         acc = out_ready && in_valid;
         if (out_ready) in_op = 1'b0;
      end
      chk("outputs", act_v, exp_v);
      if (acc) begin
         mq     = mode;
         pend_n = (n_iter > 15) ? 15 : int'(n_iter);
         in_op  = 1'b1;
         e = mode ? mk(1, 1, 1, 0, 0, 0, 0, 3, last_cnt) : mk(1, 1, 0, 0, 1, 0, 0, 0, last_cnt);
         e.is_load = 1'b1;
         q.push_back(e);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int edges, output int n_dec, output int n_op, output int n_fz);
      edges = 0; n_dec = 0; n_op = 0; n_fz = 0;
      while (!out_valid && edges < 80) begin
         n_dec += int'(load_d);
         n_op  += int'(load_x && sel_x == 2'd2);
         n_fz  += int'((load_z && sel_z == 2'd2) || (load_x && sel_x == 2'd3));
         tick();
         edges++;
      end
      if (edges >= 80) chk("timeout_out_valid", 0, 1);
   endtask

   initial begin
      int edges, n_dec, n_op, n_fz, k, ov;
      rst = 1'b0; in_valid = 1'b0; mode = 1'b0; n_iter = '0;
      neg_x = 1'b0; z_oor = 1'b0; out_ready = 1'b0;
`ifdef CORDIC_ABORT_EN
      abort = 1'b0;
`endif
      tick();
      chk("reset_in_ready", in_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_counter", iteration_counter, 0);
      tick(); rst = 1'b1;
      tick();

      // Vectoring, 4 iterations, no normalize.
      in_valid = 1'b1; mode = 1'b0; n_iter = 5'd3;
      tick();
      chk("t1_clear_z", clear_z, 1);
      in_valid = 1'b0;
      wait_out(edges, n_dec, n_op, n_fz);
      chk("t1_latency", edges, 10);
      chk("t1_decide_count", n_dec, 4);
      chk("t1_finalize_sel", n_fz, 1);
      chk("t1_counter", iteration_counter, 3);

      // Result held while downstream stalls.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1; in_valid = 1'b1; mode = 1'b1; n_iter = 5'd2; z_oor = 1'b1;
      #1 chk("b2b_in_ready", in_ready, 1);
      tick();
      chk("b2b_load_rot", {busy, load_z, sel_z}, 4'b1111);
      in_valid = 1'b0; out_ready = 1'b0;
      wait_out(edges, n_dec, n_op, n_fz);
      chk("t2_latency", edges, 9);
      chk("t2_operate_count", n_op, 3);
      chk("t2_d_src", d_src, 1);
      out_ready = 1'b1;
      tick();
      chk("t2_idle", busy, 0);

      // Iteration request above the maximum is clamped.
      in_valid = 1'b1; mode = 1'b0; n_iter = 5'd31; neg_x = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out(edges, n_dec, n_op, n_fz);
      chk("t3_operate_count", n_op, 16);
      chk("t3_counter", iteration_counter, 15);
      chk("t3_latency", edges, 35);
      tick();

      // Asynchronous reset mid-operation.
      in_valid = 1'b1; mode = 1'b1; n_iter = 5'd5; z_oor = 1'b0;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!(load_x && sel_x == 2'd2 && iteration_counter == 5'd2) && k < 40) begin
         tick(); k++;
      end
      chk("t4_reached_op2", k < 40, 1);
      rst = 1'b0;
      #1;
      chk("t4_busy", busy, 0);
      chk("t4_counter", iteration_counter, 0);
      chk("t4_in_ready", in_ready, 1);
      ov = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 2) rst = 1'b1;
         ov |= int'(out_valid);
      end
      chk("t4_no_out_valid", ov, 0);

`ifdef CORDIC_ABORT_EN
      in_valid = 1'b1; mode = 1'b0; n_iter = 5'd4; neg_x = 1'b0;
      tick();
      in_valid = 1'b0;
      k = 0;
      while (!load_d && k < 20) begin tick(); k++; end
      abort = 1'b1;
      #1 chk("ab_load_d", load_d, 0);
      tick();
      abort = 1'b0;
      chk("ab_idle", busy, 0);
      ov = 0;
      for (int i = 0; i < 10; i++) begin tick(); ov |= int'(out_valid); end
      chk("ab_no_out_valid", ov, 0);
      in_valid = 1'b1; n_iter = 5'd1;
      tick();
      in_valid = 1'b0;
      wait_out(edges, n_dec, n_op, n_fz);
      chk("ab_next_latency", edges, 6);
      tick();
`endif

      // Random traffic checked cycle by cycle against the queue model.
      for (int i = 0; i < 4000; i++) begin
         tick();
         rst       = ($urandom_range(0, 399) != 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         mode      = 1'($urandom_range(0, 1));
         n_iter    = 5'($urandom_range(0, 31));
         neg_x     = 1'($urandom_range(0, 1));
         z_oor     = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef CORDIC_ABORT_EN
         abort     = ($urandom_range(0, 59) == 0);
`endif
      end
      tick();
      rst = 1'b1; in_valid = 1'b0;
      tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
